// File: rtl/oam_dma_pkg.sv
// oam_dma_pkg: shared constants and the state encoding for the sprite-DMA engine.
//   ADDR_WIDTH / REG_WIDTH : CPU address and data widths
//   DMA_REG                : CPU address whose write starts a transfer
//   XFER_LEN / OAM_AW      : bytes per transfer and the OAM index width
package oam_dma_pkg;

  localparam int ADDR_WIDTH = 16;
  localparam int REG_WIDTH  = 8;
  localparam int XFER_LEN   = 256;
  localparam int OAM_AW     = $clog2(XFER_LEN);

  localparam logic [ADDR_WIDTH-1:0] DMA_REG = 16'h4014;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE,
    DONE
  } oam_dma_state_t;

endpackage

// File: rtl/oam_dma_if.sv
// oam_dma_if: CPU-side trigger, memory read port and OAM write port of the
// sprite-DMA engine, bundled together.
//   master : the DMA engine (drives rdy, dma_*, oam_*, done)
//   slave  : the system side (CPU strobe, memory read data)
interface oam_dma_if;
  import oam_dma_pkg::*;

  logic                  cpu_we;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [REG_WIDTH-1:0]  cpu_wdata;
  logic                  rdy;
  logic                  dma_active;
  logic [ADDR_WIDTH-1:0] dma_addr;
  logic                  dma_rd;
  logic [REG_WIDTH-1:0]  dma_rdata;
  logic [OAM_AW-1:0]     oam_addr;
  logic [REG_WIDTH-1:0]  oam_wdata;
  logic                  oam_we;
  logic                  done;

  modport master (
    input  cpu_we, cpu_addr, cpu_wdata, dma_rdata,
    output rdy, dma_active, dma_addr, dma_rd, oam_addr, oam_wdata, oam_we, done
  );

  modport slave (
    output cpu_we, cpu_addr, cpu_wdata, dma_rdata,
    input  rdy, dma_active, dma_addr, dma_rd, oam_addr, oam_wdata, oam_we, done
  );

endinterface

// File: rtl/oam_dma.sv
// oam_dma: sprite-DMA engine. A CPU write to DMA_REG latches source page P,
// halts the CPU (rdy=0) and copies XFER_LEN bytes from {P,00}.. into
// OAM[0..XFER_LEN-1], one READ/WRITE cycle pair per byte, then pulses done.
//   clk   : CPU phi0 clock
//   reset : asynchronous, active-high
//   bus   : oam_dma_if.master (CPU trigger in, rdy/dma_active out,
//           memory read port, OAM write port, done pulse)
// Every output is a pure decode of the registered state, so reset forces
// the idle output values immediately, without waiting for a clock edge.
module oam_dma
  import oam_dma_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  oam_dma_if.master  bus
);

  localparam logic [OAM_AW-1:0] CNT_LAST = OAM_AW'(XFER_LEN - 1);

  oam_dma_state_t        state, state_nxt;
  logic [REG_WIDTH-1:0]  page;
  logic [OAM_AW-1:0]     cnt;
  logic                  parity;
  logic                  trig;

  logic                  rdy, dma_active, dma_rd, oam_we, done;
  logic [ADDR_WIDTH-1:0] dma_addr;
  logic [OAM_AW-1:0]     oam_addr;
  logic [REG_WIDTH-1:0]  oam_wdata;

  // CPU reads of DMA_REG and writes elsewhere never start a transfer.
  assign trig = bus.cpu_we && (bus.cpu_addr == DMA_REG);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      page   <= '0;
      cnt    <= '0;
      parity <= 1'b0;
    end else begin
      state  <= state_nxt;
      // get/put cycle model of the CPU; decides whether an align cycle is needed
      parity <= ~parity;
      if (state == IDLE && trig) begin
        page <= bus.cpu_wdata;
        cnt  <= '0;
      end else if (state == WRITE) begin
        // wraps to zero only on the final byte, so the read address stays in-page
        cnt <= cnt + OAM_AW'(1);
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    rdy        = 1'b1;
    dma_active = 1'b0;
    dma_addr   = '0;
    dma_rd     = 1'b0;
    oam_addr   = '0;
    oam_wdata  = '0;
    oam_we     = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        if (trig) state_nxt = HALT;
      end
      HALT: begin
        // one cycle lets the triggering CPU write retire
        rdy        = 1'b0;
        dma_active = 1'b1;
        state_nxt  = parity ? ALIGN : READ;
      end
      ALIGN: begin
        rdy        = 1'b0;
        dma_active = 1'b1;
        state_nxt  = READ;
      end
      READ: begin
        rdy        = 1'b0;
        dma_active = 1'b1;
        dma_addr   = {page, cnt};
        dma_rd     = 1'b1;
        state_nxt  = WRITE;
      end
      WRITE: begin
        // memory data for the READ address arrives in this cycle
        rdy        = 1'b0;
        dma_active = 1'b1;
        oam_we     = 1'b1;
        oam_addr   = cnt;
        oam_wdata  = bus.dma_rdata;
        state_nxt  = (cnt == CNT_LAST) ? DONE : READ;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.rdy        = rdy;
  assign bus.dma_active = dma_active;
  assign bus.dma_addr   = dma_addr;
  assign bus.dma_rd     = dma_rd;
  assign bus.oam_addr   = oam_addr;
  assign bus.oam_wdata  = oam_wdata;
  assign bus.oam_we     = oam_we;
  assign bus.done       = done;

endmodule

// File: tb/tb_oam_dma.sv
// tb_oam_dma: directed bench for oam_dma. A table of single-cycle CPU
// accesses checks trigger decoding; hand-written sequences cover the full
// transfers at both parities, page FF, and asynchronous reset mid-transfer.
module tb_oam_dma;

  logic clk;
  logic reset;
  logic tb_par;
  int   checks;
  int   failures;

  oam_dma_if bus();

  oam_dma dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory contents are a fixed function of the address
  function automatic logic [7:0] memf(input logic [15:0] a);
    logic [7:0] lo;
    lo = a[7:0];
    return (lo * 8'd3) ^ a[15:8] ^ 8'h5A;
  endfunction

  // memory: data is valid one clock after the address is presented
  always @(posedge clk) bus.dma_rdata <= memf(bus.dma_addr);

  // reference get/put parity: cleared by reset, toggles every clock
  always @(posedge clk or posedge reset) begin
    if (reset) tb_par <= 1'b0;
    else       tb_par <= ~tb_par;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic cpu_idle();
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = 16'h0000;
    bus.cpu_wdata = 8'h00;
  endtask

  // Issue the trigger so that the engine sees parity==par while in HALT.
  task automatic trigger(input logic [7:0] page, input logic par);
    int n;
    n = 0;
    @(negedge clk);
    // tb_par flips at the trigger edge, so it must equal ~par beforehand
    while (tb_par !== ~par && n < 4) begin
      @(negedge clk);
      n++;
    end
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = 16'h4014;
    bus.cpu_wdata = page;
    @(posedge clk);
    #1;
    cpu_idle();
  endtask

  // Watch a whole transfer from HALT entry and check it against the model.
  task automatic run_xfer(input logic [7:0] page, input logic par, input string tag);
    int stall, rd_cnt, we_cnt, done_cnt, first_rd, bad_rd, bad_we, bad_act, bad_done;
    logic zero_seen;
    logic [7:0] last_oa;
    stall = 0; rd_cnt = 0; we_cnt = 0; done_cnt = 0; first_rd = -1;
    bad_rd = 0; bad_we = 0; bad_act = 0; bad_done = 0;
    zero_seen = 1'b0; last_oa = 8'h00;
    for (int c = 0; c < 530; c++) begin
      @(negedge clk);
      if (!bus.rdy) stall++;
      if (bus.dma_active !== ~bus.rdy) bad_act++;
      if (bus.dma_rd) begin
        if (first_rd < 0) first_rd = c;
        if (bus.dma_addr !== {page, rd_cnt[7:0]}) bad_rd++;
        if (bus.dma_addr == 16'h0000) zero_seen = 1'b1;
        rd_cnt++;
      end
      if (bus.oam_we) begin
        if (bus.oam_addr !== we_cnt[7:0] || bus.oam_wdata !== memf({page, we_cnt[7:0]}))
          bad_we++;
        last_oa = bus.oam_addr;
        we_cnt++;
      end
      if (bus.done) begin
        done_cnt++;
        if (!bus.rdy || bus.dma_active || bus.oam_we) bad_done++;
      end
    end
    chk({tag, "_stall"},    64'(stall),    par ? 64'd514 : 64'd513);
    chk({tag, "_first_rd"}, 64'(first_rd), par ? 64'd2 : 64'd1);
    chk({tag, "_rd_cnt"},   64'(rd_cnt),   64'd256);
    chk({tag, "_we_cnt"},   64'(we_cnt),   64'd256);
    chk({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
    chk({tag, "_rd_addr"},  64'(bad_rd),   64'd0);
    chk({tag, "_oam_data"}, 64'(bad_we),   64'd0);
    chk({tag, "_active"},   64'(bad_act),  64'd0);
    chk({tag, "_done_st"},  64'(bad_done), 64'd0);
    chk({tag, "_zero_adr"}, 64'(zero_seen), 64'd0);
    chk({tag, "_last_oa"},  64'(last_oa),  64'hFF);
  endtask

  function automatic logic [36:0] outs();
    return {bus.rdy, bus.dma_active, bus.dma_addr, bus.dma_rd,
            bus.oam_addr, bus.oam_wdata, bus.oam_we, bus.done};
  endfunction

  localparam logic [36:0] RST_OUTS = {1'b1, 1'b0, 16'h0000, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [4:0]  exp;   // {rdy, dma_active, dma_rd, oam_we, done}
  } vec_t;

  vec_t vt[7];

  initial begin
    int wcnt, dn, rdy_lo;
    checks   = 0;
    failures = 0;
    cpu_idle();
    reset = 1'b1;

    vt[0] = '{1'b1, 16'h4013, 8'h02, 5'b10000};
    vt[1] = '{1'b1, 16'h4015, 8'h02, 5'b10000};
    vt[2] = '{1'b0, 16'h4014, 8'h02, 5'b10000};
    vt[3] = '{1'b1, 16'h0014, 8'h02, 5'b10000};
    vt[4] = '{1'b1, 16'hC014, 8'h02, 5'b10000};
    vt[5] = '{1'b0, 16'h0000, 8'h00, 5'b10000};
    vt[6] = '{1'b1, 16'h4014, 8'h07, 5'b01000};

    repeat (3) @(negedge clk);
    chk("reset_outs", 64'(outs()), 64'(RST_OUTS));
    reset = 1'b0;

    // trigger decoding: only a CPU write to 4014 halts the CPU
    @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      bus.cpu_we    = vt[i].we;
      bus.cpu_addr  = vt[i].addr;
      bus.cpu_wdata = vt[i].wdata;
      @(negedge clk);
      chk($sformatf("vec%0d", i),
          64'({bus.rdy, bus.dma_active, bus.dma_rd, bus.oam_we, bus.done}),
          64'(vt[i].exp));
    end
    cpu_idle();
    repeat (530) @(negedge clk);
    chk("after_vec_idle", 64'(outs()), 64'(RST_OUTS));

    // full transfers at both parities
    trigger(8'h02, 1'b0);
    run_xfer(8'h02, 1'b0, "p02_par0");
    trigger(8'h02, 1'b1);
    run_xfer(8'h02, 1'b1, "p02_par1");
    trigger(8'hFF, 1'b1);
    run_xfer(8'hFF, 1'b1, "pFF");

    // asynchronous reset mid-transfer with random CPU inputs
    trigger(8'h01, 1'b0);
    repeat (20) begin
      @(negedge clk);
      bus.cpu_we    = 1'($urandom);
      bus.cpu_addr  = 16'($urandom);
      bus.cpu_wdata = 8'($urandom);
    end
    chk("mid_xfer_halted", 64'(bus.rdy), 64'd0);
    #2 reset = 1'b1;
    #1 chk("async_rst_rdy", 64'(bus.rdy), 64'd1);
    chk("async_rst_outs", 64'(outs()), 64'(RST_OUTS));
    repeat (3) begin
      @(negedge clk);
      bus.cpu_we    = 1'($urandom);
      bus.cpu_addr  = 16'h4014;
      bus.cpu_wdata = 8'($urandom);
    end
    chk("rst_held_outs", 64'(outs()), 64'(RST_OUTS));
    cpu_idle();
    reset = 1'b0;

    // reset after byte 100 of a page-03 transfer, then a clean page-04 copy
    trigger(8'h03, 1'b1);
    wcnt = 0;
    for (int c = 0; c < 600 && wcnt < 100; c++) begin
      @(negedge clk);
      if (bus.oam_we) wcnt++;
    end
    chk("p03_reached_100", 64'(wcnt), 64'd100);
    #2 reset = 1'b1;
    #1 chk("p03_rst_rdy", 64'(bus.rdy), 64'd1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    dn = 0;
    rdy_lo = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done) dn++;
      if (!bus.rdy || bus.dma_rd || bus.oam_we) rdy_lo++;
    end
    chk("p03_no_done", 64'(dn), 64'd0);
    chk("p03_quiet", 64'(rdy_lo), 64'd0);
    trigger(8'h04, 1'b0);
    run_xfer(8'h04, 1'b0, "p04");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
